branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising clock edge only.
REQ-003 SHALL have port: fetch_pc  in  12  word address of instruction in F stage (imem address width).
REQ-004 SHALL have port: pred_taken  out  1  prediction for fetch_pc; combinational from current table state.
REQ-005 SHALL have port: pred_target  out  12  predicted target for fetch_pc; 0 when pred_taken=0.
REQ-006 SHALL have port: upd_valid  in  1  X stage resolved a branch (bne/blt/j/jal/jr/bex) this cycle.
REQ-007 SHALL have ports: upd_pc in 12, upd_taken in 1, upd_target in 12  PC, outcome and actual target of resolved branch.
REQ-008 SHALL have ports: upd_pred_taken in 1, upd_pred_target in 12  prediction originally made for that branch, carried down the pipe.
REQ-009 SHALL have port: flush  out  1  kill F/D and D/X contents this cycle.
REQ-010 SHALL have port: redirect_pc  out  12  PC to load into PC register when flush=1; 0 otherwise.
REQ-011 SHALL have ports: branch_count out 32, mispredict_count out 32  registered statistics counters.

Function
REQ-012 SHALL hold a 16-entry table; entry = valid(1), tag(8), ctr(2), target(12); index = pc[3:0], tag = pc[11:4].
REQ-013 SHALL assert pred_taken iff entry[fetch_pc[3:0]] valid, tag == fetch_pc[11:4], ctr[1]==1; pred_target = entry target then.
REQ-014 SHALL assert flush = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)), combinational, same cycle.
REQ-015 SHALL drive redirect_pc = upd_target if upd_taken, else upd_pc+1 modulo 4096 (0xFFF -> 0x000), only while flush=1.
REQ-016 On upd_valid with tag hit: ctr increments saturating at 11 if taken, decrements saturating at 00 if not; target overwritten with upd_target if taken.
REQ-017 On upd_valid with miss (invalid or tag mismatch): if taken, allocate -- valid=1, tag, ctr=10, target=upd_target (replaces any resident entry); if not taken, no table change.
REQ-018 Table writes SHALL take effect at the clock edge; a fetch_pc read in the same cycle as an update to the same index SHALL see the pre-update entry.
REQ-019 branch_count SHALL increment by 1 each cycle upd_valid=1; mispredict_count by 1 each cycle flush=1; both saturate at 0xFFFFFFFF.
REQ-020 Update and prediction SHALL be independent: one prediction and one update per cycle, no stall, no backpressure.
REQ-021 Outcome/target inputs SHALL be ignored when upd_valid=0.

Reset
REQ-022 With reset=1 at an edge: all valid=0, all ctr=01, targets=0, tags=0, both counters=0.
REQ-023 While reset=1: pred_taken=0, pred_target=0, flush=0, redirect_pc=0 regardless of inputs.
REQ-024 Reset asserted together with upd_valid=1 SHALL win: no table or counter update from that cycle.
REQ-025 Reset released mid-program SHALL resume with all predictions not-taken until reallocation.

Verification
REQ-026 Cold table: reset, fetch_pc=0x010 -> pred_taken=0, pred_target=0; upd_valid=1, upd_pc=0x010, taken=1, target=0x020, pred_taken=0 -> flush=1, redirect_pc=0x020, next cycle fetch_pc=0x010 -> pred_taken=1, pred_target=0x020, mispredict_count=1.
REQ-027 Saturation: after allocation (ctr=10) apply taken twice -> ctr=11; then not-taken once -> still predicts taken (ctr=10), flush=1 with redirect_pc=0x011; second not-taken -> pred_taken=0.
REQ-028 Aliasing: entry at 0x010 allocated; update upd_pc=0x110 not-taken -> no change, 0x010 still predicted; upd_pc=0x110 taken target 0x005 -> 0x010 now predicts 0, 0x110 predicts taken to 0x005.
REQ-029 Target mismatch (jr): upd_taken=1, upd_pred_taken=1, upd_pred_target=0x030, upd_target=0x040 -> flush=1, redirect_pc=0x040, entry target becomes 0x040.
REQ-030 Wrap/same-cycle: upd_pc=0xFFF not-taken, upd_pred_taken=1 -> redirect_pc=0x000; fetch_pc=0xFFF in same cycle shows old prediction, new state next cycle.
REQ-031 Reset mid-operation: reset=1 with upd_valid=1 and a mispredict pending -> flush=0, counters=0 next cycle, all fetches predict not-taken.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side update bundle for the branch predictor.
// The slave modport is the predictor's view; the master modport is the pipeline's view.
interface branch_predictor_if;
  localparam int unsigned PC_W  = 12;
  localparam int unsigned CNT_W = 32;

  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [PC_W-1:0]  upd_pred_target;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, flush, redirect_pc,
           branch_count, mispredict_count
  );

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, flush, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// 16-entry direct-mapped branch target buffer with 2-bit saturating counters,
// same-cycle mispredict flush/redirect and saturating branch/mispredict statistics.
module branch_predictor (
  input  logic               clock,
  input  logic               reset,
  branch_predictor_if.slave  bp
);
  localparam int unsigned PC_W    = 12;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
    logic [PC_W-1:0]  target;
  } entry_t;

  entry_t            r_table [ENTRIES];
  logic [CNT_W-1:0]  r_branch_count;
  logic [CNT_W-1:0]  r_mispredict_count;

  entry_t            w_rd;
  entry_t            w_upd;
  entry_t            w_new;
  logic              w_pred_taken;
  logic              w_upd_hit;
  logic              w_mismatch;
  logic              w_flush;
  logic              w_wr_en;
  logic [PC_W-1:0]   w_redirect_pc;
  logic [IDX_W-1:0]  w_f_idx;
  logic [IDX_W-1:0]  w_u_idx;

  assign w_f_idx = bp.fetch_pc[IDX_W-1:0];
  assign w_u_idx = bp.upd_pc[IDX_W-1:0];

  // Prediction reads the pre-update table; reset forces everything quiet.
  always_comb begin
    w_rd         = r_table[w_f_idx];
    w_pred_taken = !reset && w_rd.valid &&
                   (w_rd.tag == bp.fetch_pc[PC_W-1:IDX_W]) && w_rd.ctr[1];
  end

  always_comb begin
    w_mismatch    = (bp.upd_taken != bp.upd_pred_taken) ||
                    (bp.upd_taken && bp.upd_pred_taken &&
                     (bp.upd_target != bp.upd_pred_target));
    w_flush       = !reset && bp.upd_valid && w_mismatch;
    w_redirect_pc = '0;
    if (w_flush) begin
      w_redirect_pc = bp.upd_taken ? bp.upd_target : (bp.upd_pc + PC_W'(1));
    end
  end

  // Next value of the entry addressed by the resolving branch.
  always_comb begin
    w_upd     = r_table[w_u_idx];
    w_new     = w_upd;
    w_wr_en   = 1'b0;
    w_upd_hit = w_upd.valid && (w_upd.tag == bp.upd_pc[PC_W-1:IDX_W]);
    if (bp.upd_valid) begin
      if (w_upd_hit) begin
        w_wr_en = 1'b1;
        if (bp.upd_taken) begin
          w_new.ctr    = (w_upd.ctr == 2'b11) ? 2'b11 : (w_upd.ctr + 2'(1));
          w_new.target = bp.upd_target;
        end else begin
          w_new.ctr    = (w_upd.ctr == 2'b00) ? 2'b00 : (w_upd.ctr - 2'(1));
        end
      end else if (bp.upd_taken) begin
        w_wr_en      = 1'b1;
        w_new.valid  = 1'b1;
        w_new.tag    = bp.upd_pc[PC_W-1:IDX_W];
        w_new.ctr    = 2'b10;
        w_new.target = bp.upd_target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_table[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, target: '0};
      end
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_table[w_u_idx] <= w_new;
      end
      if (bp.upd_valid && (r_branch_count != '1)) begin
        r_branch_count <= r_branch_count + CNT_W'(1);
      end
      if (w_flush && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end

  assign bp.pred_taken       = w_pred_taken;
  assign bp.pred_target      = w_pred_taken ? w_rd.target : '0;
  assign bp.flush            = w_flush;
  assign bp.redirect_pc      = w_redirect_pc;
  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;
endmodule
